// File: rtl/tx_burst_pkg.sv
// tx_burst_pkg: shared widths, I/Q field layout and FSM states for the burst framer
package tx_burst_pkg;
  localparam int DATA_W = 48;
  localparam int LEN_W = 16;
  localparam int IQ_W = 24;
  localparam int I_LSB = 24;
  localparam int Q_LSB = 0;
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DONE} state_t;
endpackage

// File: rtl/tx_burst_framer_preamble_gen.sv
// tx_preamble_gen: alternating +/-amplitude I word with Q=0, zero when not advancing
module tx_preamble_gen #(
  parameter int DATA_W = tx_burst_pkg::DATA_W
) (
  input  logic [11:0]       amplitude,
  input  logic              odd,
  input  logic              advance,
  output logic [DATA_W-1:0] word
);
  import tx_burst_pkg::*;
  logic signed [IQ_W-1:0] i_val;
  always_comb begin
    i_val = IQ_W'(signed'(amplitude));
    word = '0;
    word[I_LSB +: IQ_W] = advance ? (odd ? -i_val : i_val) : '0;
  end
endmodule

// File: rtl/tx_burst_framer.sv
// tx_burst_framer: preamble + payload burst framer; define TX_UNDERRUN_ZERO_FILL_EN to zero-fill source underruns
module tx_burst_framer #(
  parameter int DATA_W = tx_burst_pkg::DATA_W,
  parameter int LEN_W = tx_burst_pkg::LEN_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cfg_enable,
  input  logic [LEN_W-1:0]  cfg_PREAMBLE_LEN,
  input  logic [LEN_W-1:0]  cfg_PAYLOAD_LEN,
  input  logic [11:0]       cfg_AMPLITUDE,
  input  logic              start,
  input  logic [DATA_W-1:0] fifo_in_rddata,
  input  logic              fifo_in_empty,
  output logic              fifo_in_rdreq,
  output logic [DATA_W-1:0] fifo_out_wrdata,
  output logic              fifo_out_wrreq,
  input  logic              fifo_out_full,
  output logic              busy,
  output logic [31:0]       debug_burst_count
);
  import tx_burst_pkg::*;
  state_t state, state_n;
  logic [LEN_W-1:0] cnt, pre_len, pay_len;
  logic [11:0] amp;
  logic advance, last, in_pay, src_ok;
  logic [DATA_W-1:0] pre_word, pay_word;
`ifdef TX_UNDERRUN_ZERO_FILL_EN
  assign src_ok = 1'b1;
  assign pay_word = fifo_in_empty ? '0 : fifo_in_rddata;
`else
  assign src_ok = !fifo_in_empty;
  assign pay_word = fifo_in_rddata;
`endif
  assign in_pay = state == PAYLOAD;
  assign advance = cfg_enable && !fifo_out_full && (state == PREAMBLE || (in_pay && src_ok));
  assign last = cnt == (in_pay ? pay_len : pre_len) - 1'b1;
  assign fifo_in_rdreq = advance && in_pay && !fifo_in_empty;
  assign busy = state != IDLE;
  tx_preamble_gen #(.DATA_W(DATA_W)) u_pre (
    .amplitude(amp),
    .odd(cnt[0]),
    .advance(advance),
    .word(pre_word)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start && cfg_enable)
        state_n = cfg_PREAMBLE_LEN != '0 ? PREAMBLE : cfg_PAYLOAD_LEN != '0 ? PAYLOAD : DONE;
      PREAMBLE: if (advance && last) state_n = pay_len != '0 ? PAYLOAD : DONE;
      PAYLOAD: if (advance && last) state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (!cfg_enable) state_n = IDLE;
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= IDLE;
      cnt <= '0;
      pre_len <= '0;
      pay_len <= '0;
      amp <= '0;
      fifo_out_wrreq <= 1'b0;
      fifo_out_wrdata <= '0;
      debug_burst_count <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : advance ? cnt + 1'b1 : cnt;
      if (state == IDLE && state_n != IDLE) begin
        pre_len <= cfg_PREAMBLE_LEN;
        pay_len <= cfg_PAYLOAD_LEN;
        amp <= cfg_AMPLITUDE;
      end
      fifo_out_wrreq <= advance;
      if (advance) fifo_out_wrdata <= in_pay ? pay_word : pre_word;
      if (state == DONE && cfg_enable) debug_burst_count <= debug_burst_count + 1'b1;
    end
  end
endmodule
